// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// The queue entry pairs each instruction with the PC it was fetched from.
package cpu_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int INSTR_BYTES = DATA_WIDTH / 8;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with a flush that overrides push and pop.
// The head is read straight from registered storage, so it has no input-to-output path.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Next-state pointers and occupancy
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents past the occupancy are never observed
   always_ff @(posedge clk) begin
      if (rst && !flush && push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads memory combinationally and
// queues {pc, instr} pairs for decode; a redirect flushes and restarts fetch.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
   parameter int                    DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    QUEUE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] instruction_addr,
   input  logic [DATA_WIDTH-1:0] instruction_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   input  logic                  out_ready
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         count_s;
   logic                  pop_s;
   logic                  push_s;
   fetch_entry_t          push_data_s;
   fetch_entry_t          head_s;

   assign out_valid = (count_s != {CW{1'b0}});
   assign pop_s     = out_valid && out_ready;
   // A full queue still accepts a fetch when its head leaves in the same cycle
   assign push_s    = !redirect_valid && ((count_s < CW'(QUEUE_DEPTH)) || pop_s);

   assign push_data_s.pc    = pc_q;
   assign push_data_s.instr = instruction_data;

   // PC advance: redirect wins, otherwise step only when the fetch was queued
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (push_s) begin
         pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
      end else begin
         pc_d = pc_q;
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (head_s),
      .count     (count_s)
   );

   assign instruction_addr = pc_q;
   assign out_pc           = head_s.pc;
   assign out_instr        = head_s.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model queues expected entries
// at each clock edge and compares them against the DUT head on the falling edge.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;
   logic [31:0] instruction_addr, instruction_data;
   logic        out_valid;
   logic [31:0] out_pc, out_instr;

   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic [31:0] w_instruction_addr, w_instruction_data;
   logic        w_out_valid;
   logic [31:0] w_out_pc, w_out_instr;

   fetch_entry_t sb_q[$];
   logic [31:0]  m_pc;
   int           n_checks = 0;
   int           n_fail   = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign instruction_data   = mem_f(instruction_addr);
   assign w_instruction_data = mem_f(w_instruction_addr);

   fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .instruction_addr (instruction_addr),
      .instruction_data (instruction_data),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .out_valid        (out_valid),
      .out_pc           (out_pc),
      .out_instr        (out_instr),
      .out_ready        (out_ready)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk              (clk),
      .rst              (rst),
      .instruction_addr (w_instruction_addr),
      .instruction_data (w_instruction_data),
      .redirect_valid   (w_redirect_valid),
      .redirect_pc      (w_redirect_pc),
      .out_valid        (w_out_valid),
      .out_pc           (w_out_pc),
      .out_instr        (w_out_instr),
      .out_ready        (out_ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour at a rising edge, using the inputs held across it
   task automatic model_step();
      bit           pop;
      bit           push;
      fetch_entry_t e;
      pop = (sb_q.size() > 0) && out_ready;
      if (!rst) begin
         sb_q.delete();
         m_pc = 32'h0;
      end else if (redirect_valid) begin
         sb_q.delete();
         m_pc = redirect_pc;
      end else begin
         push = (sb_q.size() < 2) || pop;
         if (pop) void'(sb_q.pop_front());
         if (push) begin
            e.pc    = m_pc;
            e.instr = mem_f(m_pc);
            sb_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_outputs();
      check_eq("instruction_addr", {32'h0, instruction_addr}, {32'h0, m_pc});
      if (sb_q.size() > 0) begin
         check_eq("out_valid", {63'h0, out_valid}, 64'h1);
         check_eq("out_pc",    {32'h0, out_pc},    {32'h0, sb_q[0].pc});
         check_eq("out_instr", {32'h0, out_instr}, {32'h0, sb_q[0].instr});
      end else begin
         check_eq("out_valid", {63'h0, out_valid}, 64'h0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
   endtask

   initial begin
      logic [31:0] prev_pc;
      rst              = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'h0;
      out_ready        = 1'b1;
      w_redirect_valid = 1'b0;
      w_redirect_pc    = 32'h0;
      m_pc             = 32'h0;

      // Reset, then streaming with decode always ready
      cycle();
      cycle();
      check_eq("wrap_reset_valid", {63'h0, w_out_valid}, 64'h0);
      check_eq("wrap_reset_addr", {32'h0, w_instruction_addr}, 64'hFFFF_FFFC);
      rst = 1'b1;
      cycle();
      check_eq("wrap_first_valid", {63'h0, w_out_valid}, 64'h1);
      check_eq("wrap_first_pc", {32'h0, w_out_pc}, 64'hFFFF_FFFC);
      cycle();
      check_eq("wrap_second_pc", {32'h0, w_out_pc}, 64'h0);
      check_eq("wrap_second_instr", {32'h0, w_out_instr}, {32'h0, mem_f(32'h0)});
      for (int i = 0; i < 4; i++) cycle();

      // Decode stalled from release: queue fills and pc holds
      rst = 1'b0;
      cycle();
      rst       = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      check_eq("stall_addr_hold", {32'h0, instruction_addr}, 64'h8);
      check_eq("stall_head_pc", {32'h0, out_pc}, 64'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Full queue streaming: head advances one instruction per cycle
      for (int i = 0; i < 3; i++) begin
         prev_pc = out_pc;
         cycle();
         check_eq("stream_advance", {32'h0, out_pc}, {32'h0, prev_pc + 32'd4});
      end

      // Redirect on a full queue with a simultaneous pop
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      cycle();
      redirect_valid = 1'b0;
      check_eq("redir_valid_low", {63'h0, out_valid}, 64'h0);
      check_eq("redir_addr", {32'h0, instruction_addr}, 64'h100);
      cycle();
      check_eq("redir_head_pc", {32'h0, out_pc}, 64'h100);

      // Back-to-back redirects, the second byte-granular
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      cycle();
      redirect_pc    = 32'h203;
      cycle();
      redirect_valid = 1'b0;
      check_eq("redir_b2b_addr", {32'h0, instruction_addr}, 64'h203);
      for (int i = 0; i < 3; i++) cycle();

      // Random backpressure and occasional redirects
      for (int i = 0; i < 80; i++) begin
         out_ready      = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = $urandom & 32'h0000_FFFF;
         cycle();
      end

      // Reset overrides a pending redirect on a full queue
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      cycle();
      cycle();
      rst            = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      out_ready      = 1'b1;
      cycle();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      check_eq("rst_over_redir_valid", {63'h0, out_valid}, 64'h0);
      check_eq("rst_over_redir_addr", {32'h0, instruction_addr}, 64'h0);
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
